// File: rtl/glb_rd_pkg.sv
// Shared types and helpers for the global-buffer read-channel scheduler.
package glb_rd_pkg;

  localparam int unsigned GlbRdBwDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } glb_rd_state_e;

  // LSB position of field idx in a vector of packed w-bit fields.
  function automatic int field_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant: first set request at or above ptr, wrapping at NREQ. Purely combinational.
module rr_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/glb_rd_sched.sv
// Read-channel scheduler: round-robin arbitration of NREQ loaders onto one DRAM read bus,
// one burst in flight, returned beats steered to the granted loader with burst-length checking.
module glb_rd_sched
  import glb_rd_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned BW   = GlbRdBwDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*BW-1:0] req_len,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      araddr,
  output logic [BW-1:0]      arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [DW-1:0]      rdata,
  input  logic               rlast,
  output logic [NREQ-1:0]    rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               rd_last,
  output logic               busy,
  output logic               err
);

  localparam int unsigned PW = $clog2(NREQ);

  glb_rd_state_e   state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            arvalid_q, arvalid_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [BW-1:0]   arburst_q, arburst_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_last_q, rd_last_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] req_ready_c;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            at_len;

  rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx)
  );

  // arburst_q doubles as the registered burst length for the end-of-burst check.
  assign at_len = (cnt_q == arburst_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arburst_d   = arburst_q;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    rd_last_d   = 1'b0;
    err_d       = 1'b0;
    req_ready_c = '0;

    unique case (state_q)
      StIdle: begin
        err_d = rvalid;
        if (|req_valid) begin
          req_ready_c = arb_gnt;
          gidx_d      = arb_idx;
          araddr_d    = req_addr[field_lsb(int'(arb_idx), int'(AW)) +: AW];
          arburst_d   = req_len[field_lsb(int'(arb_idx), int'(BW)) +: BW];
          arvalid_d   = 1'b1;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        // Data may not precede address acceptance, so even a same-cycle beat is stray.
        err_d = rvalid;
        if (arready) begin
          arvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (rvalid) begin
          rd_valid_d = NREQ'(1) << gidx_q;
          rd_data_d  = rdata;
          cnt_d      = cnt_q + BW'(1);
          if (rlast || at_len) begin
            rd_last_d = 1'b1;
            err_d     = rlast != at_len;
            state_d   = StIdle;
            ptr_d     = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gidx_q     <= '0;
      cnt_q      <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arburst_q  <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      cnt_q      <= cnt_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arburst_q  <= arburst_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = req_ready_c & {NREQ{~rst}};
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arburst   = arburst_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_glb_rd_sched.sv
// Randomized bench for glb_rd_sched: a transaction-level model tracks pending requests,
// the round-robin pointer and expected beat/error outcomes for each burst.
module tb_glb_rd_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned BW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*BW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      araddr;
  logic [BW-1:0]      arburst;
  logic               arvalid;
  logic               arready;
  logic               rvalid;
  logic [DW-1:0]      rdata;
  logic               rlast;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;
  logic               rd_last;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  glb_rd_sched #(
    .NREQ(NREQ),
    .DW  (DW),
    .AW  (AW),
    .BW  (BW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_ready(req_ready),
    .araddr   (araddr),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rlast    (rlast),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy),
    .err      (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ptr   = 0;
  int unsigned pend  = 0;
  logic [AW-1:0] cur_addr[NREQ];
  logic [AW-1:0] nxt_addr[NREQ];
  logic [BW-1:0] cur_len[NREQ];
  logic [BW-1:0] nxt_len[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i*AW +: AW] = cur_addr[i];
      req_len[i*BW +: BW]  = cur_len[i];
    end
    req_valid = NREQ'(pend);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arburst"}, 32'(arburst), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_last"}, 32'(rd_last), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
  endtask

  // One arbitration + burst, entered in an IDLE cycle. mode: 0 normal, 1 early rlast, 2 no rlast.
  task automatic do_round(input int unsigned newm, input int ar_delay, input int mode_in,
                          input int early_k, input bit stray_idle, input bit stray_addr,
                          input int gap_pct);
    int          g, i, mode, len, nb, gaps;
    bit          s;
    int unsigned oh;
    logic [DW-1:0] d;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (((newm >> j) & 1) != 0 && ((pend >> j) & 1) == 0) begin
        cur_addr[j] = nxt_addr[j];
        cur_len[j]  = nxt_len[j];
        pend        = pend | (1 << j);
      end
    end
    if (pend == 0) begin
      cur_addr[0] = nxt_addr[0];
      cur_len[0]  = nxt_len[0];
      pend        = 1;
    end
    g = -1;
    for (int j = 0; j < int'(NREQ); j++) begin
      i = (ptr + j) % NREQ;
      if (g < 0 && ((pend >> i) & 1) != 0) g = i;
    end
    oh   = 1 << g;
    len  = int'(cur_len[g]);
    mode = (mode_in == 1 && len == 0) ? 0 : mode_in;
    nb   = (mode == 1) ? ((early_k - 1) % len + 1) : len + 1;

    // IDLE: arbitration; a random arready here must be ignored.
    drive_req();
    arready = 1'($urandom_range(0, 1));
    rvalid  = stray_idle;
    rdata   = $urandom;
    rlast   = 1'b0;
    #1;
    chk("req_ready", 32'(req_ready), oh);
    chk("busy_idle", 32'(busy), 0);
    tick();
    pend      = pend & ~oh;
    req_valid = NREQ'(pend);
    arready   = 1'b0;
    rvalid    = 1'b0;
    chk("err_stray_idle", 32'(err), 32'(stray_idle));
    chk("rd_valid_idle", 32'(rd_valid), 0);

    // ADDR: address held until accepted.
    for (int c = 0; c <= ar_delay; c++) begin
      chk("arvalid", 32'(arvalid), 1);
      chk("araddr", araddr, cur_addr[g]);
      chk("arburst", 32'(arburst), 32'(cur_len[g]));
      chk("busy_addr", 32'(busy), 1);
      s       = stray_addr && (c == 0);
      arready = (c == ar_delay);
      rvalid  = s;
      rdata   = $urandom;
      tick();
      arready = 1'b0;
      rvalid  = 1'b0;
      chk("err_stray_addr", 32'(err), 32'(s));
      chk("rd_valid_addr", 32'(rd_valid), 0);
    end
    chk("arvalid_drop", 32'(arvalid), 0);

    // DATA
    for (int b = 1; b <= nb; b++) begin
      gaps = 0;
      while (gaps < 3 && $urandom_range(0, 99) < gap_pct) begin
        gaps++;
        tick();
        chk("rd_valid_gap", 32'(rd_valid), 0);
        chk("err_gap", 32'(err), 0);
      end
      d      = $urandom;
      rvalid = 1'b1;
      rdata  = d;
      rlast  = (mode != 2) && (b == nb);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk("rd_valid", 32'(rd_valid), oh);
      chk("rd_data", rd_data, d);
      chk("rd_last", 32'(rd_last), 32'(b == nb));
      chk("err_beat", 32'(err), 32'((b == nb) && (mode != 0)));
    end
    ptr = (g + 1) % NREQ;
  endtask

  task automatic reset_mid_burst();
    int          j;
    int unsigned oh;
    j           = $urandom_range(0, NREQ - 1);
    oh          = 1 << j;
    cur_addr[j] = $urandom;
    cur_len[j]  = 4'hf;
    pend        = oh;
    drive_req();
    #1;
    chk("rst_req_ready", 32'(req_ready), oh);
    tick();
    pend      = 0;
    req_valid = '0;
    arready   = 1'b1;
    tick();
    arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      tick();
      chk("rst_pre_rd_valid", 32'(rd_valid), oh);
    end
    rst   = 1'b1;
    rdata = $urandom;
    tick();
    rst    = 1'b0;
    rvalid = 1'b0;
    chk_all_zero("midrst");
    ptr = 0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      tick();
      chk("post_rst_err", 32'(err), 1);
      chk("post_rst_rd_valid", 32'(rd_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    rvalid = 1'b0;
    tick();
    chk("post_rst_err_clear", 32'(err), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_len   = '0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rlast     = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // All three together, len 0, twice: order 0,1,2 then 0,1,2 after the wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        nxt_addr[i] = $urandom;
        nxt_len[i]  = '0;
      end
      for (int k = 0; k < int'(NREQ); k++) do_round((k == 0) ? 7 : 0, 0, 0, 1, 0, 0, 0);
    end

    // Single request, requester 0 at 0x1000, 4 beats.
    nxt_addr[0] = 32'h1000;
    nxt_len[0]  = 4'd3;
    do_round(1, 0, 0, 1, 0, 0, 0);
    // arready delayed 5 cycles.
    nxt_addr[1] = 32'hdead_beec;
    nxt_len[1]  = 4'd2;
    do_round(2, 5, 0, 1, 0, 0, 0);
    // len 7, rlast on beat 4.
    nxt_addr[2] = 32'h0000_2000;
    nxt_len[2]  = 4'd7;
    do_round(4, 0, 1, 4, 0, 0, 0);
    // len 1, rlast never comes.
    nxt_addr[0] = 32'h0000_3000;
    nxt_len[0]  = 4'd1;
    do_round(1, 1, 2, 1, 0, 0, 0);
    // Stray beat in IDLE, then a stray beat coinciding with arready.
    nxt_addr[1] = 32'h0000_4000;
    nxt_len[1]  = 4'd0;
    do_round(2, 2, 0, 1, 1, 0, 0);
    nxt_addr[2] = 32'h0000_5000;
    nxt_len[2]  = 4'd1;
    do_round(4, 0, 0, 1, 0, 1, 0);

    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        nxt_addr[i] = $urandom;
        nxt_len[i]  = BW'($urandom_range(0, 15));
      end
      do_round($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(1, 16), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0), 30);
    end
    while (pend != 0) do_round(0, 0, 0, 1, 0, 0, 20);

    reset_mid_burst();
    // Pointer restarts at 0 after reset.
    for (int i = 0; i < int'(NREQ); i++) begin
      nxt_addr[i] = $urandom;
      nxt_len[i]  = BW'($urandom_range(0, 3));
    end
    for (int k = 0; k < int'(NREQ); k++) do_round((k == 0) ? 7 : 0, 1, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
